// File: rtl/jtcontra_snd_post.sv
// Stereo post-processing for the FM output: a gain stage with saturation and a one-pole low-pass filter.
// Both channels share one multiplier and one filter adder, so a sample takes five cycles to process.
module jtcontra_snd_post (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   input  logic [7:0]  gain,
   input  logic [2:0]  lpf_k,
   input  logic        mute,
   output logic [15:0] snd_left,
   output logic [15:0] snd_right,
   output logic        sample_out,
   output logic        clip,
   output logic        overrun
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] GAIN_L = 3'd1;
   localparam logic [2:0] GAIN_R = 3'd2;
   localparam logic [2:0] FILT_L = 3'd3;
   localparam logic [2:0] FILT_R = 3'd4;

   localparam logic signed [24:0] SAT_MAX = 25'sd32767;
   localparam logic signed [24:0] SAT_MIN = -25'sd32768;

   logic [2:0]         state;
   logic               sample_d;
   logic               armed;
   logic               sample_rise;
   logic [15:0]        left_q;
   logic [15:0]        right_q;
   logic [7:0]         gain_q;
   logic [2:0]         k_q;
   logic               mute_q;
   logic [15:0]        x_l;
   logic [15:0]        x_r;
   logic [15:0]        y_l;
   logic [15:0]        y_r;
   logic               clip_l;
   logic               clip_r;

   logic signed [24:0] mul_a;
   logic signed [24:0] mul_b;
   logic signed [24:0] prod;
   logic signed [24:0] shifted;
   logic [15:0]        sat_val;
   logic               sat_flag;
   logic [15:0]        gained;

   logic [15:0]        x_sel;
   logic [15:0]        y_sel;
   logic signed [16:0] diff;
   logic signed [15:0] step;
   logic [15:0]        y_next;

   // armed stays low until sample is seen low, so a level held through reset is not an edge
   assign sample_rise = sample & ~sample_d & armed;
   assign overrun     = sample_rise & (state != IDLE) & ~rst;

   // One multiplier serves both channels: left in GAIN_L, right in GAIN_R
   always_comb begin
      mul_a    = (state == GAIN_R) ? {{9{right_q[15]}}, right_q} : {{9{left_q[15]}}, left_q};
      mul_b    = {17'd0, gain_q};
      prod     = mul_a * mul_b;
      shifted  = prod >>> 4;
      sat_flag = 1'b0;
      if (shifted > SAT_MAX) begin
         sat_val  = 16'h7FFF;
         sat_flag = 1'b1;
      end else if (shifted < SAT_MIN) begin
         sat_val  = 16'h8000;
         sat_flag = 1'b1;
      end else begin
         sat_val  = shifted[15:0];
      end
      gained = mute_q ? 16'd0 : sat_val;
   end

   // The filter result always lies between x and y, so truncating the step to 16 bits is safe
   always_comb begin
      x_sel  = (state == FILT_R) ? x_r : x_l;
      y_sel  = (state == FILT_R) ? y_r : y_l;
      diff   = $signed({x_sel[15], x_sel}) - $signed({y_sel[15], y_sel});
      step   = 16'(diff >>> k_q);
      y_next = (k_q == 3'd0) ? x_sel : y_sel + step;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sample_d   <= 1'b0;
         armed      <= ~sample;
         left_q     <= 16'd0;
         right_q    <= 16'd0;
         gain_q     <= 8'd0;
         k_q        <= 3'd0;
         mute_q     <= 1'b0;
         x_l        <= 16'd0;
         x_r        <= 16'd0;
         y_l        <= 16'd0;
         y_r        <= 16'd0;
         clip_l     <= 1'b0;
         clip_r     <= 1'b0;
         snd_left   <= 16'd0;
         snd_right  <= 16'd0;
         sample_out <= 1'b0;
         clip       <= 1'b0;
      end else begin
         sample_d   <= sample;
         armed      <= armed | ~sample;
         sample_out <= 1'b0;
         clip       <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_rise) begin
                  left_q  <= left_in;
                  right_q <= right_in;
                  gain_q  <= gain;
                  k_q     <= lpf_k;
                  mute_q  <= mute;
                  state   <= GAIN_L;
               end
            end
            GAIN_L: begin
               x_l    <= gained;
               clip_l <= sat_flag;
               state  <= GAIN_R;
            end
            GAIN_R: begin
               x_r    <= gained;
               clip_r <= sat_flag;
               state  <= FILT_L;
            end
            FILT_L: begin
               y_l   <= y_next;
               state <= FILT_R;
            end
            FILT_R: begin
               y_r        <= y_next;
               snd_left   <= y_l;
               snd_right  <= y_next;
               sample_out <= 1'b1;
               clip       <= clip_l | clip_r;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtcontra_snd_post.sv
// Directed bench for jtcontra_snd_post: a table of single-sample vectors plus
// hand-written sequences for overrun, back-to-back acceptance and reset corner cases.
module tb_jtcontra_snd_post;

   logic        clk;
   logic        rst;
   logic        sample;
   logic [15:0] left_in;
   logic [15:0] right_in;
   logic [7:0]  gain;
   logic [2:0]  lpf_k;
   logic        mute;
   logic [15:0] snd_left;
   logic [15:0] snd_right;
   logic        sample_out;
   logic        clip;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [15:0] l;
      logic [15:0] r;
      logic [7:0]  g;
      logic [2:0]  k;
      logic        m;
      logic [15:0] el;
      logic [15:0] er;
      logic        ec;
   } vec_t;

   vec_t vecs[11];

   jtcontra_snd_post dut (
      .clk        (clk),
      .rst        (rst),
      .sample     (sample),
      .left_in    (left_in),
      .right_in   (right_in),
      .gain       (gain),
      .lpf_k      (lpf_k),
      .mute       (mute),
      .snd_left   (snd_left),
      .snd_right  (snd_right),
      .sample_out (sample_out),
      .clip       (clip),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Moves into the next cycle, drives sample for it, then leaves time for outputs to settle
   task automatic driveCycle(input logic s);
      @(posedge clk);
      #1;
      sample = s;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic setInputs(input logic [15:0] l, input logic [15:0] r, input logic [7:0] g,
                            input logic [2:0] k, input logic m);
      left_in  = l;
      right_in = r;
      gain     = g;
      lpf_k    = k;
      mute     = m;
   endtask

   // Issues one sample edge and checks latency, outputs, clip and pulse width
   task automatic applyStimulus(input vec_t v);
      int lat;
      setInputs(v.l, v.r, v.g, v.k, v.m);
      driveCycle(1'b1);
      checkOutput({v.name, "_no_overrun"}, {15'd0, overrun}, 16'd0);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         driveCycle(1'b0);
         if (sample_out) begin
            lat = i;
            break;
         end
      end
      checkOutput({v.name, "_latency"}, 16'(lat), 16'd5);
      checkOutput({v.name, "_left"}, snd_left, v.el);
      checkOutput({v.name, "_right"}, snd_right, v.er);
      checkOutput({v.name, "_clip"}, {15'd0, clip}, {15'd0, v.ec});
      driveCycle(1'b0);
      checkOutput({v.name, "_pulse_end"}, {15'd0, sample_out}, 16'd0);
      checkOutput({v.name, "_clip_end"}, {15'd0, clip}, 16'd0);
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{"unity",     16'h1234, 16'hEDCC, 8'h10, 3'd0, 1'b0, 16'h1234, 16'hEDCC, 1'b0};
      vecs[1]  = '{"saturate",  16'h4000, 16'hC000, 8'hFF, 3'd0, 1'b0, 16'h7FFF, 16'h8000, 1'b1};
      vecs[2]  = '{"half_floor",16'hFFFF, 16'h0010, 8'h08, 3'd0, 1'b0, 16'hFFFF, 16'h0008, 1'b0};
      vecs[3]  = '{"double",    16'h0100, 16'hFF00, 8'h20, 3'd0, 1'b0, 16'h0200, 16'hFE00, 1'b0};
      vecs[4]  = '{"zero",      16'h0000, 16'h0000, 8'h10, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vecs[5]  = '{"filt1",     16'h4000, 16'h0000, 8'h10, 3'd1, 1'b0, 16'h2000, 16'h0000, 1'b0};
      vecs[6]  = '{"filt2",     16'h4000, 16'h0000, 8'h10, 3'd1, 1'b0, 16'h3000, 16'h0000, 1'b0};
      vecs[7]  = '{"filt3",     16'h4000, 16'h0000, 8'h10, 3'd1, 1'b0, 16'h3800, 16'h0000, 1'b0};
      vecs[8]  = '{"mute1",     16'h4000, 16'h0000, 8'h10, 3'd1, 1'b1, 16'h1C00, 16'h0000, 1'b0};
      vecs[9]  = '{"mute2",     16'h4000, 16'h0000, 8'h10, 3'd1, 1'b1, 16'h0E00, 16'h0000, 1'b0};
      vecs[10] = '{"bypass_ret",16'h8001, 16'h7FFE, 8'h10, 3'd0, 1'b0, 16'h8001, 16'h7FFE, 1'b0};

      rst    = 1'b1;
      sample = 1'b1;
      setInputs(16'h5A5A, 16'hA5A5, 8'h10, 3'd0, 1'b0);
      repeat (3) driveCycle(1'b1);
      checkOutput("reset_left", snd_left, 16'h0000);
      checkOutput("reset_right", snd_right, 16'h0000);
      checkOutput("reset_sample_out", {15'd0, sample_out}, 16'd0);
      checkOutput("reset_clip", {15'd0, clip}, 16'd0);
      checkOutput("reset_overrun", {15'd0, overrun}, 16'd0);

      // Sample held high across reset release must not start a conversion
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         driveCycle(1'b1);
         if (sample_out) pulses++;
      end
      checkOutput("held_high_no_edge", 16'(pulses), 16'd0);
      driveCycle(1'b0);
      driveCycle(1'b0);

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

      // Overrun at N+2, then a new edge accepted exactly at N+5
      setInputs(16'h1111, 16'h2222, 8'h10, 3'd0, 1'b0);
      driveCycle(1'b1);
      checkOutput("ovr_first_accept", {15'd0, overrun}, 16'd0);
      driveCycle(1'b0);
      setInputs(16'h3333, 16'h4444, 8'h10, 3'd0, 1'b0);
      driveCycle(1'b1);
      checkOutput("ovr_pulse", {15'd0, overrun}, 16'd1);
      driveCycle(1'b0);
      checkOutput("ovr_one_cycle", {15'd0, overrun}, 16'd0);
      driveCycle(1'b0);
      setInputs(16'h5555, 16'h6666, 8'h10, 3'd0, 1'b0);
      driveCycle(1'b1);
      checkOutput("ovr_out_n5", {15'd0, sample_out}, 16'd1);
      checkOutput("ovr_left_first", snd_left, 16'h1111);
      checkOutput("ovr_right_first", snd_right, 16'h2222);
      checkOutput("ovr_edge_n5_accepted", {15'd0, overrun}, 16'd0);
      pulses = 0;
      for (int i = 6; i <= 9; i++) begin
         driveCycle(1'b0);
         if (sample_out) pulses++;
         checkOutput("ovr_hold_left", snd_left, 16'h1111);
      end
      checkOutput("ovr_no_extra_pulse", 16'(pulses), 16'd0);
      driveCycle(1'b0);
      checkOutput("ovr_out_n10", {15'd0, sample_out}, 16'd1);
      checkOutput("ovr_left_second", snd_left, 16'h5555);
      checkOutput("ovr_right_second", snd_right, 16'h6666);

      // Reset at N+2 aborts the sample and clears the filter state
      repeat (2) driveCycle(1'b0);
      setInputs(16'h7777, 16'h7777, 8'h10, 3'd0, 1'b0);
      driveCycle(1'b1);
      driveCycle(1'b0);
      driveCycle(1'b0);
      rst = 1'b1;
      driveCycle(1'b0);
      rst = 1'b0;
      checkOutput("midrst_left", snd_left, 16'h0000);
      checkOutput("midrst_right", snd_right, 16'h0000);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         driveCycle(1'b0);
         if (sample_out) pulses++;
      end
      checkOutput("midrst_no_pulse", 16'(pulses), 16'd0);
      applyStimulus('{"after_rst", 16'h4000, 16'hC000, 8'h10, 3'd1, 1'b0, 16'h2000, 16'hE000, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtcontra_snd_post.md
JTCONTRA_SND_POST -- requirements
Module: jtcontra_snd_post

Interface
REQ-001 SHALL have port clk, input, 1: system clock, 24 MHz; the single clock for all logic.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port sample, input, 1: FM sample marker; a rising edge means new stereo data is present.
REQ-004 SHALL have port left_in, input, 16: signed left sample from the FM core's full-resolution output.
REQ-005 SHALL have port right_in, input, 16: signed right sample from the FM core's full-resolution output.
REQ-006 SHALL have port gain, input, 8: unsigned 4.4 gain; 8'h10 is unity.
REQ-007 SHALL have port lpf_k, input, 3: one-pole low-pass shift; 0 is bypass.
REQ-008 SHALL have port mute, input, 1: forces the filter input to zero.
REQ-009 SHALL have port snd_left, output, 16: signed processed left sample, registered.
REQ-010 SHALL have port snd_right, output, 16: signed processed right sample, registered.
REQ-011 SHALL have port sample_out, output, 1: one-cycle pulse when snd_left/snd_right update.
REQ-012 SHALL have port clip, output, 1: one-cycle pulse when either channel saturates in the gain stage.
REQ-013 SHALL have port overrun, output, 1: one-cycle pulse when a sample edge is dropped because the block is busy.

Function
REQ-014 SHALL detect a sample rising edge from a registered copy of sample (sample=1 now, 0 in the previous cycle); a level held high SHALL NOT retrigger.
REQ-015 SHALL capture left_in, right_in, gain, lpf_k and mute in edge-detect cycle N, but only when the FSM is in IDLE.
REQ-016 SHALL run the FSM IDLE -> GAIN_L (N+1) -> GAIN_R (N+2) -> FILT_L (N+3) -> FILT_R (N+4) -> IDLE.
REQ-017 SHALL update snd_left/snd_right and pulse sample_out in cycle N+5; fixed latency is 5 cycles.
REQ-018 SHALL share a single 16x8 multiplier between the two channels (time-multiplexed); no parallel multipliers.
REQ-019 SHALL form the gain product as signed 16-bit x {1'b0,gain} (24 bits), then apply an arithmetic right shift by 4 (floor rounding).
REQ-020 SHALL saturate the shifted product to [-32768, 32767] and pulse clip in N+5 if either channel saturated.
REQ-021 SHALL replace the gained value x with 0 when the captured mute=1; the filter still runs, so the output decays.
REQ-022 SHALL keep per-channel 16-bit filter state y and update y <= y + ((x - y) >>> k), where x - y is computed in 17 bits and the shift is arithmetic.
REQ-023 SHALL set y <= x when k=0 (bypass).
REQ-024 SHALL drive snd_left/snd_right from the updated y.
REQ-025 SHALL NOT overflow the filter update; the result lies between x and y by construction, and no saturation logic is required there.
REQ-026 SHALL ignore a rising edge that arrives in any non-IDLE state; captured data SHALL stay unchanged and overrun SHALL pulse in that cycle.
REQ-027 SHALL treat an edge arriving in the same cycle the FSM returns to IDLE (N+5) as accepted, with capture in that cycle.
REQ-028 SHALL keep snd_left/snd_right stable between sample_out pulses.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, return the FSM to IDLE and clear snd_left, snd_right, both filter states and the captured registers to 0.
REQ-030 SHALL, on reset, clear sample_out, clip, overrun and the edge-detect register to 0.
REQ-031 SHALL abort any sample in flight when reset is asserted mid-operation; no sample_out pulse for it.
REQ-032 SHALL NOT treat a sample input held high through reset release as an edge.

Verification
REQ-033 Unity bypass: gain=10h, k=0, left_in=1234h, right_in=EDCCh, edge at N -> snd_left=1234h, snd_right=EDCCh, sample_out=1 at N+5 only, clip=0.
REQ-034 Saturation: gain=FFh, left_in=4000h, right_in=C000h -> snd_left=7FFFh, snd_right=8000h, clip pulses at N+5; separately, gain=08h, left_in=FFFFh -> FFFFh (floor).
REQ-035 Filter step: k=1, unity gain, state 0, three samples of left_in=4000h -> snd_left 2000h, 3000h, 3800h; mute=1 afterwards -> 1C00h, 0E00h.
REQ-036 Overrun: second edge at N+2 -> overrun pulse at N+2, outputs reflect only the first sample at N+5; an edge exactly at N+5 is accepted, with its output at N+10.
REQ-037 Reset mid-op: edge at N, rst at N+2 -> no sample_out, outputs 0; the next edge after release processes normally from zero filter state.
